// File: rtl/cond_exec_unit.sv
// Execute-stage conditional-execution unit.
// Holds the D->E register for the condition/control fields and the
// architectural NZCV flags. It evaluates the condition field of the
// instruction in E against the flags left by earlier instructions, gates
// the write-type controls, and updates the flags from the ALU result.
// There is no handshake here: the pipeline advances on every clock edge
// unless StallE holds it or FlushE replaces the E contents with a bubble.
module cond_exec_unit #(
   parameter logic [3:0] RESET_FLAGS = 4'b0000,
   parameter bit         NV_EXEC     = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] CondD,
   input  logic [1:0] FlagWD,
   input  logic       PCSD,
   input  logic       RegWD,
   input  logic       MemWD,
   input  logic       BranchD,
   input  logic       NoWriteD,
   input  logic       StallE,
   input  logic       FlushE,
   input  logic [3:0] ALUFlags,
   output logic [3:0] CondE,
   output logic [3:0] FlagsE,
   output logic       CondExE,
   output logic       PCSrcE,
   output logic       RegWriteE,
   output logic       MemWriteE,
   output logic       BranchTakenE
);

   // "Always" condition: what a bubble carries, so a bubble passes the
   // check but has no control bits to gate through.
   localparam logic [3:0] COND_AL = 4'b1110;

   logic [3:0] cond_e;
   logic [1:0] flag_we_e;
   logic       pcs_e;
   logic       reg_w_e;
   logic       mem_w_e;
   logic       branch_e;
   logic       no_write_e;
   logic [3:0] flags;
   logic       cond_ex;
   logic       flag_n;
   logic       flag_z;
   logic       flag_c;
   logic       flag_v;

   // E register: reset and flush both load the bubble; stall holds.
   always_ff @(posedge clk) begin
      if (reset || FlushE) begin
         cond_e     <= COND_AL;
         flag_we_e  <= 2'b00;
         pcs_e      <= 1'b0;
         reg_w_e    <= 1'b0;
         mem_w_e    <= 1'b0;
         branch_e   <= 1'b0;
         no_write_e <= 1'b0;
      end else if (!StallE) begin
         cond_e     <= CondD;
         flag_we_e  <= FlagWD;
         pcs_e      <= PCSD;
         reg_w_e    <= RegWD;
         mem_w_e    <= MemWD;
         branch_e   <= BranchD;
         no_write_e <= NoWriteD;
      end
   end

   // Flags register: the instruction in E writes NZ and/or CV only when its
   // condition passes and E is not stalled. A flush does not cancel the
   // instruction currently in E, only what follows it.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags <= RESET_FLAGS;
      end else if (!StallE) begin
         if (flag_we_e[1] && cond_ex) begin
            flags[3:2] <= ALUFlags[3:2];
         end
         if (flag_we_e[0] && cond_ex) begin
            flags[1:0] <= ALUFlags[1:0];
         end
      end
   end

   // Condition check against the registered flags (results of prior
   // instructions), zero latency from CondE.
   always_comb begin
      flag_n  = flags[3];
      flag_z  = flags[2];
      flag_c  = flags[1];
      flag_v  = flags[0];
      cond_ex = 1'b0;
      case (cond_e)
         4'b0000: cond_ex = flag_z;
         4'b0001: cond_ex = ~flag_z;
         4'b0010: cond_ex = flag_c;
         4'b0011: cond_ex = ~flag_c;
         4'b0100: cond_ex = flag_n;
         4'b0101: cond_ex = ~flag_n;
         4'b0110: cond_ex = flag_v;
         4'b0111: cond_ex = ~flag_v;
         4'b1000: cond_ex = flag_c & ~flag_z;
         4'b1001: cond_ex = ~flag_c | flag_z;
         4'b1010: cond_ex = (flag_n == flag_v);
         4'b1011: cond_ex = (flag_n != flag_v);
         4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_ex = flag_z | (flag_n != flag_v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = NV_EXEC;
      endcase
   end

   // Gated controls: nothing with side effects leaves E unless the
   // condition passes; compare-type instructions never write registers.
   always_comb begin
      CondE        = cond_e;
      FlagsE       = flags;
      CondExE      = cond_ex;
      PCSrcE       = pcs_e & cond_ex;
      RegWriteE    = reg_w_e & ~no_write_e & cond_ex;
      MemWriteE    = mem_w_e & cond_ex;
      BranchTakenE = branch_e & cond_ex;
   end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Bench for cond_exec_unit: directed steps plus a short random phase.
// A reference model predicts the E-stage outputs at every edge; the
// prediction is queued when the inputs are driven and compared after the
// edge. Directed constant checks cover the cases called out in the plan.
module tb_cond_exec_unit;

   localparam logic [3:0] RESET_FLAGS = 4'b0000;
   localparam bit         NV_EXEC     = 1'b0;
   localparam int         W           = 13;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cond_d;
   logic [1:0] flag_w_d;
   logic       pcs_d, reg_w_d, mem_w_d, branch_d, no_write_d;
   logic       stall_e, flush_e;
   logic [3:0] alu_flags;
   logic [3:0] cond_e_o, flags_e_o;
   logic       cond_ex_o, pc_src_o, reg_write_o, mem_write_o, branch_taken_o;

   cond_exec_unit #(.RESET_FLAGS(RESET_FLAGS), .NV_EXEC(NV_EXEC)) dut (
      .clk(clk), .reset(reset), .CondD(cond_d), .FlagWD(flag_w_d),
      .PCSD(pcs_d), .RegWD(reg_w_d), .MemWD(mem_w_d), .BranchD(branch_d),
      .NoWriteD(no_write_d), .StallE(stall_e), .FlushE(flush_e),
      .ALUFlags(alu_flags), .CondE(cond_e_o), .FlagsE(flags_e_o),
      .CondExE(cond_ex_o), .PCSrcE(pc_src_o), .RegWriteE(reg_write_o),
      .MemWriteE(mem_write_o), .BranchTakenE(branch_taken_o)
   );

   // Clock
   always #5 clk = ~clk;

   // Scoreboard and counters
   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state (E register and flags)
   logic [3:0] m_cond, m_flags;
   logic [1:0] m_fwe;
   logic       m_pcs, m_regw, m_memw, m_br, m_nowr;

   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cc, v;
      {n, z, cc, v} = f;
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cc;
         4'h3: return !cc;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cc && !z;
         4'h9: return !cc || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return NV_EXEC;
      endcase
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_bubble();
      m_cond = 4'b1110; m_fwe = 2'b00;
      m_pcs = 0; m_regw = 0; m_memw = 0; m_br = 0; m_nowr = 0;
   endtask

   // Advance one clock: predict, queue, clock, compare.
   task automatic tick();
      logic cx;
      logic [W-1:0] e;
      cx = cond_ok(m_cond, m_flags);
      if (reset) begin
         m_flags = RESET_FLAGS;
         model_bubble();
      end else begin
         if (!stall_e) begin
            if (m_fwe[1] && cx) m_flags[3:2] = alu_flags[3:2];
            if (m_fwe[0] && cx) m_flags[1:0] = alu_flags[1:0];
         end
         if (flush_e) model_bubble();
         else if (!stall_e) begin
            m_cond = cond_d; m_fwe = flag_w_d; m_pcs = pcs_d; m_regw = reg_w_d;
            m_memw = mem_w_d; m_br = branch_d; m_nowr = no_write_d;
         end
      end
      cx = cond_ok(m_cond, m_flags);
      e = {m_cond, m_flags, cx, m_pcs & cx, m_regw & ~m_nowr & cx, m_memw & cx, m_br & cx};
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check("e_outputs",
            {cond_e_o, flags_e_o, cond_ex_o, pc_src_o, reg_write_o, mem_write_o, branch_taken_o},
            exp_q.pop_front());
   endtask

   // Driver for the decode-side fields
   task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic pcs,
                        input logic rw, input logic mw, input logic br, input logic nw);
      cond_d = c; flag_w_d = fw; pcs_d = pcs; reg_w_d = rw;
      mem_w_d = mw; branch_d = br; no_write_d = nw;
   endtask

   // Load flags to v via an AL instruction that writes NZ and CV; leaves a
   // harmless AL no-op in E.
   task automatic set_flags(input logic [3:0] v);
      drive(4'b1110, 2'b11, 0, 0, 0, 0, 0);
      tick();
      alu_flags = v;
      drive(4'b1110, 2'b00, 0, 0, 0, 0, 0);
      tick();
      check("set_flags", flags_e_o, v);
   endtask

   logic [3:0] sweep_flags[4] = '{4'b0100, 4'b1001, 4'b0010, 4'b1111};

   initial begin
      reset = 1; stall_e = 0; flush_e = 0; alu_flags = 4'($urandom_range(0, 15));
      drive(4'($urandom_range(0, 15)), 2'b11, 1, 1, 1, 1, 0);
      model_bubble();
      m_flags = RESET_FLAGS;

      // 1. Reset for two cycles with arbitrary D inputs
      tick();
      alu_flags = 4'($urandom_range(0, 15));
      tick();
      check("rst_cond", cond_e_o, 4'b1110);
      check("rst_flags", flags_e_o, 4'b0000);
      check("rst_condex", cond_ex_o, 1'b1);
      check("rst_gated", {pc_src_o, reg_write_o, mem_write_o, branch_taken_o}, 4'b0000);
      reset = 0;

      // 2. Condition sweep over several flag values
      foreach (sweep_flags[i]) begin
         set_flags(sweep_flags[i]);
         for (int c = 0; c < 16; c++) begin
            drive(4'(c), 2'b00, 0, 0, 0, 0, 0);
            tick();
            if (sweep_flags[i] == 4'b0100) begin
               if (c == 0) check("flags0100_eq", cond_ex_o, 1'b1);
               if (c == 1) check("flags0100_ne", cond_ex_o, 1'b0);
               if (c == 8) check("flags0100_hi", cond_ex_o, 1'b0);
               if (c == 9) check("flags0100_ls", cond_ex_o, 1'b1);
            end
            if (sweep_flags[i] == 4'b1001) begin
               if (c == 10) check("flags1001_ge", cond_ex_o, 1'b1);
               if (c == 11) check("flags1001_lt", cond_ex_o, 1'b0);
               if (c == 12) check("flags1001_gt", cond_ex_o, 1'b1);
            end
            if (c == 15) check("nv", cond_ex_o, NV_EXEC);
         end
      end

      // 3. Gating
      set_flags(4'b0000);
      drive(4'b0000, 2'b00, 1, 1, 1, 1, 0);
      tick();
      check("gate_eq_fail", {pc_src_o, reg_write_o, mem_write_o, branch_taken_o}, 4'b0000);
      drive(4'b0001, 2'b00, 1, 1, 1, 1, 0);
      tick();
      check("gate_ne_pass", {pc_src_o, reg_write_o, mem_write_o, branch_taken_o}, 4'b1111);
      drive(4'b0001, 2'b00, 1, 1, 1, 1, 1);
      tick();
      check("gate_nowrite", {pc_src_o, reg_write_o, mem_write_o, branch_taken_o}, 4'b1011);

      // 4. Partial flag writes
      set_flags(4'b1111);
      drive(4'b1110, 2'b10, 0, 0, 0, 0, 0);
      tick();
      alu_flags = 4'b0000;
      drive(4'b1110, 2'b01, 0, 0, 0, 0, 0);
      tick();
      check("partial_nz", flags_e_o, 4'b0011);
      alu_flags = 4'b1010;
      drive(4'b0000, 2'b11, 0, 0, 0, 0, 0);
      tick();
      check("partial_cv", flags_e_o, 4'b0010);
      alu_flags = 4'b1111;
      drive(4'b1110, 2'b00, 0, 0, 0, 0, 0);
      tick();
      check("failed_cond_no_write", flags_e_o, 4'b0010);

      // 5. Stall and flush
      drive(4'b1110, 2'b11, 0, 0, 1, 0, 0);
      tick();
      stall_e = 1;
      for (int k = 0; k < 3; k++) begin
         alu_flags = 4'(k * 5 + 1);
         drive(4'($urandom_range(0, 15)), 2'b11, 0, 0, 0, 0, 0);
         tick();
         check("stall_memw", mem_write_o, 1'b1);
         check("stall_flags", flags_e_o, 4'b0010);
      end
      flush_e = 1;
      tick();
      check("flush_memw", mem_write_o, 1'b0);
      check("flush_cond", cond_e_o, 4'b1110);
      stall_e = 0; flush_e = 0;

      // 6. Back-to-back dependency
      set_flags(4'b0000);
      drive(4'b1110, 2'b11, 0, 0, 0, 0, 1);
      tick();
      alu_flags = 4'b0100;
      drive(4'b0000, 2'b00, 1, 0, 0, 1, 0);
      tick();
      check("b2b_taken", {branch_taken_o, pc_src_o}, 2'b11);
      // Same sequence with reset at the flag-setting edge
      set_flags(4'b0000);
      drive(4'b1110, 2'b11, 0, 0, 0, 0, 1);
      tick();
      alu_flags = 4'b0100;
      drive(4'b0000, 2'b00, 1, 0, 0, 1, 0);
      reset = 1;
      tick();
      check("b2b_rst_flags", flags_e_o, RESET_FLAGS);
      reset = 0;
      tick();
      check("b2b_rst_not_taken", {branch_taken_o, pc_src_o}, 2'b00);

      // Random phase, checked against the model
      for (int k = 0; k < 200; k++) begin
         reset     = ($urandom_range(0, 31) == 0);
         stall_e   = ($urandom_range(0, 4) == 0);
         flush_e   = ($urandom_range(0, 5) == 0);
         alu_flags = 4'($urandom_range(0, 15));
         drive(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
         tick();
      end

      check("queue_empty", 16'(exp_q.size()), 16'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
